// File: rtl/asu_pkg.sv
// Shared encodings for the handshaked add/subtract/shift unit.
package asu_pkg;

  typedef enum logic [1:0] {
    ASU_ADD = 2'b00,
    ASU_SUB = 2'b01,
    ASU_SHL = 2'b10,
    ASU_SRA = 2'b11
  } asu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } asu_state_e;

endpackage

// File: rtl/asu_seq_if.sv
// Operand/result valid-ready bus between the source, asu_seq and the sink.
interface asu_seq_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;

  modport master (
    output in_valid, mode, x, y, out_ready,
    input  in_ready, out_valid, out, carry
  );

  modport slave (
    input  in_valid, mode, x, y, out_ready,
    output in_ready, out_valid, out, carry
  );

endinterface

// File: rtl/asu_addsub.sv
// W-bit adder/subtractor; cout is carry for ADD and no-borrow for SUB.
module asu_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] y_eff_s;

  assign y_eff_s     = sub ? ~y : y;
  assign {cout, sum} = {1'b0, x} + {1'b0, y_eff_s} + {{W{1'b0}}, sub};

endmodule

// File: rtl/asu_seq.sv
// Handshaked add/sub/shift unit; shifts run serially one bit per clock.
module asu_seq
  import asu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     reset,
  asu_seq_if.slave bus
);

  localparam int AW = $clog2(W);
  localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] CNT_ONE  = AW'(1'b1);

  asu_state_e   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic         carry_q, carry_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic         sra_q, sra_d;
  logic         in_ready_q;
  logic         out_valid_q;

  asu_mode_e    mode_s;
  logic [AW-1:0] amt_s;
  logic [W-1:0] sum_s;
  logic         cout_s;

  assign mode_s = asu_mode_e'(bus.mode);
  assign amt_s  = bus.y[AW-1:0];

  asu_addsub #(.W(W)) u_addsub (
    .x    (bus.x),
    .y    (bus.y),
    .sub  (mode_s == ASU_SUB),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Next-state, datapath and shift-counter decode.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sra_d   = sra_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          case (mode_s)
            ASU_ADD, ASU_SUB: begin
              out_d   = sum_s;
              carry_d = cout_s;
              state_d = ST_DONE;
            end
            ASU_SHL, ASU_SRA: begin
              out_d   = bus.x;
              carry_d = 1'b0;
              cnt_d   = amt_s;
              sra_d   = (mode_s == ASU_SRA);
              state_d = (amt_s == CNT_ZERO) ? ST_DONE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sra_q) begin
          carry_d = out_q[0];
          out_d   = {out_q[W-1], out_q[W-1:1]};
        end else begin
          carry_d = out_q[W-1];
          out_d   = {out_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; handshake flags track the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= {W{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= CNT_ZERO;
      sra_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sra_q       <= sra_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_asu_seq.sv
// Randomised scoreboard bench for asu_seq (W=8) against an arithmetic reference model.
module tb_asu_seq;

  typedef struct {
    logic [7:0] o;
    logic       c;
    int         due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   nasserts;
  int   nfail;
  exp_t q[$];

  asu_seq_if #(.W(8)) bus ();

  asu_seq #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nasserts++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Reference: {carry, out} from plain integer arithmetic; amount = y mod 8.
  function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    int k, s, sa;
    logic [8:0] r;
    k = int'(b) % 8;
    case (m)
      2'b00: begin s = int'(a) + int'(b); r = s[8:0]; end
      2'b01: begin s = int'(a) - int'(b); r = {(a >= b), s[7:0]}; end
      2'b10: begin s = int'(a) << k; r = s[8:0]; end
      default: begin
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        s  = sa >>> k;
        r  = {((k > 0) ? a[k-1] : 1'b0), s[7:0]};
      end
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [1:0] m, input logic [7:0] b);
    return m[1] ? (int'(b) % 8) + 1 : 1;
  endfunction

  // Issue one transaction, drive ignored garbage while busy, then drain with backpressure.
  task automatic issue(input logic [1:0] m, input logic [7:0] xv, input logic [7:0] yv,
                       input int rst_at, input int hold);
    logic [8:0] e;
    exp_t       ent;
    int         k;
    bit         acc;
    bit         done;
    acc = 1'b0;
    done = 1'b0;
    k = m[1] ? int'(yv) % 8 : 0;
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.x = xv;
    bus.y = yv;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    e = model(m, xv, yv);
    ent.o = e[7:0];
    ent.c = e[8];
    ent.due = cyc + latency(m, yv);
    q.push_back(ent);
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.mode = 2'($urandom_range(0, 3));
      bus.x = 8'($urandom);
      bus.y = 8'($urandom);
      bus.out_ready = (i >= hold) && ($urandom_range(0, 3) != 0);
      if (rst_at >= 0 && i == rst_at) begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (m[1] && k > 0 && i <= k) begin
        e = model(m, xv, 8'(i));
        chk("shift_out", 32'(bus.out), 32'(e[7:0]));
        chk("shift_carry", 32'(bus.carry), 32'(e[8]));
        if (i < k) chk("shift_busy_valid", 32'(bus.out_valid), 32'd0);
      end
      if (reset) begin
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        q.delete();
        @(posedge clk); #1;
        return;
      end
      if (bus.out_valid && bus.out_ready) begin
        done = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      chk("result_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end
  endtask

  // Monitor: pop and compare on each new result, check hold-stability under backpressure.
  initial begin
    logic       prev_valid;
    logic [7:0] held_o;
    logic       held_c;
    exp_t       ent;
    prev_valid = 1'b0;
    held_o = 8'h00;
    held_c = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          nasserts++;
          nfail++;
          $display("FAIL unexpected_result: got out=0x%0h valid, expected no result", bus.out);
        end else begin
          ent = q.pop_front();
          chk("result_out", 32'(bus.out), 32'(ent.o));
          chk("result_carry", 32'(bus.carry), 32'(ent.c));
          chk("result_latency_cycle", 32'(cyc), 32'(ent.due));
        end
        held_o = bus.out;
        held_c = bus.carry;
      end else if (bus.out_valid && prev_valid) begin
        chk("hold_out", 32'(bus.out), 32'(held_o));
        chk("hold_carry", 32'(bus.carry), 32'(held_c));
      end
      if (bus.out_valid) chk("in_ready_while_valid", 32'(bus.in_ready), 32'd0);
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    nasserts = 0;
    nfail = 0;
    cyc = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode = 2'b00;
    bus.x = 8'h00;
    bus.y = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out", 32'(bus.out), 32'd0);
    chk("reset_carry", 32'(bus.carry), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    issue(2'b00, 8'hF0, 8'h20, -1, 0);
    issue(2'b01, 8'h05, 8'h07, -1, 1);
    issue(2'b01, 8'h07, 8'h05, -1, 0);
    issue(2'b01, 8'h33, 8'h33, -1, 0);
    issue(2'b10, 8'h81, 8'h03, -1, 0);
    issue(2'b11, 8'h90, 8'h0C, -1, 2);
    issue(2'b11, 8'h90, 8'h08, -1, 0);
    issue(2'b10, 8'hA5, 8'h07, -1, 0);
    issue(2'b00, 8'h01, 8'h01, -1, 5);
    issue(2'b00, 8'h7F, 8'h80, -1, 0);
    issue(2'b10, 8'hFF, 8'h07, 2, 0);
    repeat (8) @(posedge clk);
    #1;
    issue(2'b11, 8'h40, 8'h02, -1, 0);

    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), -1, $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_results", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule

// File: doc/asu_seq.md
# asu_seq

Parametrised, handshaked successor to the 8-bit add/shift unit. Accepts one operand pair per transaction and performs add, subtract, logical shift-left or arithmetic shift-right. Shifts are executed serially at one bit per clock by a small FSM. Sits between an operand source and a result sink, both using valid/ready, and produces a W-bit result plus a carry bit. The `{carry, out}` pair keeps the same meaning as the legacy 9-bit result.

## Interface
- `W`, 8: data width; must be ≥ 2.
- `AW`, `$clog2(W)`: shift-amount width; derived, not overridden.
- `clk` in 1: single clock; rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operand pair presented.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `mode` in 2: 00 ADD, 01 SUB, 10 SHL, 11 SRA.
- `x` in W: first operand / shift source.
- `y` in W: second operand; for shifts only `y[AW-1:0]` is used as the amount.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: sink accepts result.
- `out` out W: result.
- `carry` out 1: carry / no-borrow / last shifted-out bit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept occurs when `in_valid && in_ready` at a rising edge. `mode`, `x` and `y` are captured at that edge and ignored afterwards.
- **ADD:** `{carry, out} = x + y`, a (W+1)-bit unsigned sum. Goes IDLE→DONE.
- **SUB:** `{carry, out} = x + ~y + 1`. `carry` = 1 iff `x >= y` unsigned, i.e. no borrow. Goes IDLE→DONE.
- **SHL / SRA with amount 0:** `out = x`, `carry = 0`. Goes IDLE→DONE.
- **SHL / SRA with amount k > 0:** load `out = x`, `carry = 0`, shift counter = k. Goes IDLE→SHIFT.
- **SHIFT state, each cycle:**
  - SHL: `carry` ← `out[W-1]`, `out` ← `{out[W-2:0], 0}`.
  - SRA: `carry` ← `out[0]`, `out` ← `{out[W-1], out[W-1:1]}`.
  - The counter decrements each cycle; when it reaches 0, go SHIFT→DONE.
- **DONE:** `out_valid = 1`; `out` and `carry` are held stable. On `out_ready`, go DONE→IDLE.
- `in_valid` outside IDLE is ignored. The upstream holds its operands until it sees `in_ready`.
- `in_ready` = (state == IDLE); `out_valid` = (state == DONE). Both are decoded from registered state only, with no input-to-output combinational path.
- Reset (synchronous, any state, including mid-SHIFT): on the next edge, state = IDLE, `out` = 0, `carry` = 0, shift counter = 0. Any in-flight transaction is discarded with no result emitted.
- Reset values: `out` = 0, `carry` = 0, `out_valid` = 0, `in_ready` = 1.

## Timing
- ADD, SUB and zero-amount shifts: accept at edge E, `out_valid` high in the cycle after E. Latency 1.
- Shift by k ≥ 1: accept at E, k shift edges, `out_valid` high after edge E+k. Latency k+1.
- Result accept at edge R: `in_ready` high in the cycle after R. The minimum issue interval is therefore latency + 1 cycles.
- Backpressure: while `out_valid && !out_ready`, every output is frozen.
- `reset` has priority over every handshake at the same edge.

## Structure
- Shared package `asu_pkg` holds:
  - mode encodings `ASU_ADD`, `ASU_SUB`, `ASU_SHL`, `ASU_SRA`;
  - FSM state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- One combinational sub-module, `asu_addsub` (W param, inputs `x`, `y`, `sub`; outputs `sum[W-1:0]`, `cout`), is instantiated for ADD/SUB.
- FSM, shift register and counter live in the top level.

## Test plan
All scenarios use W=8.
- **ADD:** x=0xF0, y=0x20 → out=0x10, carry=1; `out_valid` in the cycle after accept.
- **SUB:** x=0x05, y=0x07 → out=0xFE, carry=0. Then x=0x07, y=0x05 → out=0x02, carry=1.
- **SHL:** x=0x81, y=0x03 → out=0x08, carry=0. `out_valid` after 3 shift edges; intermediate carry sequence 1, 0, 0.
- **SRA with amount masking:** x=0x90, y=0x0C (amount 4) → out=0xF9, carry=0. Also y=0x08 (amount 0) → out=0x90, carry=0 with latency 1.
- **Backpressure:** hold `out_ready=0` for 5 cycles after ADD 0x01+0x01. `out`=0x02 stays stable, `in_ready`=0, and a toggling `in_valid` with new operands is not captured. After `out_ready`, the next transaction is accepted and computed correctly.
- **Reset mid-operation:** SHL x=0xFF, y=0x07, assert `reset` on the 3rd SHIFT cycle. The next cycle shows `out_valid`=0, `in_ready`=1, `out`=0x00, `carry`=0, and no stale result appears afterwards.
